fifo_rd_adapter: RTL
====================

# fifo_rd_adapter

Read-side adapter for `async_fifo` (built with `OUTPUT_REG=1`), running entirely in the read clock domain. It drives the FIFO's `rd_en` from the FIFO's `empty_out` and hides the one-cycle RAM read latency. It presents FIFO contents downstream as a valid/ready stream with full throughput, using a 2-entry skid buffer. Downstream consumers connect here and never touch `rd_en` or `empty_out` directly.

## Interface
- `DATA_WIDTH`, 8, word width; must match `async_fifo.DATA_WIDTH`.
- `CNT_WIDTH`, 16, width of the delivered-word counter; only used when the counter is compiled in.

- `rd_clk`  in  1  read-domain clock; same clock as `async_fifo.rd_clk`.
- `rst_glb_n`  in  1  reset, asynchronous assert, active-low.
- `fifo_rd_en`  out  1  to `async_fifo.rd_en`.
- `fifo_rd_data`  in  DATA_WIDTH  from `async_fifo.rd_data`; valid the cycle after `fifo_rd_en` is sampled.
- `fifo_empty`  in  1  from `async_fifo.empty_out`.
- `m_valid`  out  1  downstream word available.
- `m_ready`  in  1  downstream accepts.
- `m_data`  out  DATA_WIDTH  downstream word.
- `word_cnt`  out  CNT_WIDTH  count of completed handshakes; present only with `FIFO_RD_ADAPTER_CNT_EN`.

## Operation
- **State:**
  - `occ` (0..2): skid entries holding data.
  - `inflight` (0/1): a read was issued last cycle and its data lands this cycle.
  - 1-bit write pointer and 1-bit read pointer into the 2-entry buffer.
- **Pop:** `pop = m_valid && m_ready`.
- **Read issue (combinational):** `fifo_rd_en = rst_glb_n && !fifo_empty && (occ + inflight - pop) < 2`.
  - This creates a combinational path `m_ready -> fifo_rd_en`; it is intentional and required for 1 word/cycle throughput.
- **Edge update:**
  - `inflight <= fifo_rd_en`.
  - If `inflight`, write `fifo_rd_data` at the write pointer and toggle the pointer.
  - If `pop`, toggle the read pointer.
  - `occ <= occ + inflight - pop`.
- **Output:** `m_valid = (occ != 0)` and `m_data = buf[rd_ptr]`, both driven from registers and muxes only.
- **Overflow/underflow:** the credit rule makes buffer overflow impossible (`occ + inflight <= 2` always holds). The adapter never reads while `fifo_empty=1`. Either condition occurring is a bug; the bench asserts on both.
- **Simultaneous land and pop at `occ=2`:** cannot happen, because `inflight=1` implies `occ <= 1` at that edge.
- **Simultaneous land and pop at `occ=1`:** `occ` stays 1 and the pointers advance together.
- **Downstream stall:** `m_data` is held stable while `m_valid && !m_ready`. `m_ready` is ignored when `m_valid=0`.
- **Reset mid-operation:** `occ`, `inflight` and both pointers clear immediately. A word already read from the FIFO but not delivered is discarded. Because the FIFO shares `rst_glb_n`, this is consistent.

## Timing
- **Reset values:**
  - `m_valid=0`.
  - `fifo_rd_en=0`, held low while `rst_glb_n=0`.
  - `m_data=0`, as the buffer is cleared.
  - `word_cnt=0`.
- **Latency:** with `fifo_rd_en` high in cycle N, `fifo_rd_data` is valid in N+1, and `m_valid`/`m_data` present the word in N+2.
- **First word after empty deasserts:** `fifo_empty` low in cycle N gives `m_valid` high in N+2.
- **Throughput:** 1 word/cycle sustained while `m_ready=1` and the FIFO is non-empty.
- **After downstream deasserts `m_ready`:** at most 2 words are buffered; `fifo_rd_en` stays low until a pop frees credit.
- **After `m_ready` reasserts:** `fifo_rd_en` reasserts in the same cycle.

## Configuration
- `FIFO_RD_ADAPTER_CNT_EN` defined:
  - `word_cnt` port exists.
  - It increments by 1 on every `pop` edge.
  - It wraps modulo 2^CNT_WIDTH.
  - It is cleared by reset.
- Not defined: `word_cnt` port and its register are absent; all other behaviour is identical.

## Structure
- **Shared package `fifo_pkg`:**
  - `FIFO_RD_LATENCY = 1`
  - `RD_SKID_DEPTH = 2`
  - a typedef for the 2-bit occupancy count (shared with future FIFO-side adapters)
- **Sub-module `fifo_rd_skid`:**
  - Contains the 2-entry buffer, the pointers and `occ`.
  - Inputs: `push`, `push_data`, `pop`.
  - Outputs: `occ`, `head_data`.
- **Top level:** credit logic, `inflight` flag and optional counter.

## Test plan
- **Free-flowing read:** write 16 words (0x00–0x0F) into `async_fifo` with `m_ready=1` -> `m_data` shows 0x00..0x0F on consecutive cycles, no gaps once streaming, `word_cnt=16`.
- **Downstream stall:** FIFO holds 8 words, `m_ready=0` for 10 cycles -> exactly 2 `fifo_rd_en` pulses, `m_data=0x00` held stable. Then `m_ready=1` -> 0x00..0x07 delivered in order with no loss or duplication.
- **Toggling ready:** `m_ready` toggles every cycle during a 16-word transfer -> all 16 words are received in order and `fifo_rd_en` never asserts while `fifo_empty=1`.
- **Partial fill:** write 4 words (0x10–0x13), keep `m_ready=1` -> `m_valid` rises 2 cycles after `fifo_empty` falls; 4 words are delivered, then `m_valid=0`.
- **Reset mid-operation:** assert `rst_glb_n=0` mid-transfer with 2 words buffered -> `m_valid=0` and `fifo_rd_en=0` immediately, `word_cnt=0`; after release, a new 3-word stream is delivered correctly.
- **Counter wrap:** build with `CNT_WIDTH=4`, `FIFO_RD_ADAPTER_CNT_EN` defined, transfer 18 words -> `word_cnt=2`.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the async_fifo side adapters: read latency, skid depth,
// the occupancy count type and the read-credit rule.
package fifo_pkg;

    localparam int unsigned FIFO_RD_LATENCY = 1;
    localparam int unsigned RD_SKID_DEPTH   = 2;

    typedef logic [1:0] occ_t;

    // A read may issue only if the word it returns still fits once it lands
    function automatic logic has_credit(input occ_t occ, input logic inflight, input logic pop);
        logic [2:0] w_need;
        w_need = 3'(occ) + 3'(inflight) - 3'(pop);
        return w_need < 3'(RD_SKID_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer: words land at the write pointer, the head is always
// presented at the read pointer, occ tracks how many entries hold data.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output occ_t                  occ,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] r_buf [RD_SKID_DEPTH];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    occ_t                  r_occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RD_SKID_DEPTH); i++) begin
                r_buf[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= '0;
        end else begin
            if (push) begin
                r_buf[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + occ_t'(push) - occ_t'(pop);
        end
    end

    assign occ       = r_occ;
    assign head_data = r_buf[r_rd_ptr];

endmodule

// File: rtl/fifo_rd_adapter.sv
// Read-side adapter turning async_fifo (OUTPUT_REG=1) into a valid/ready stream.
// Define FIFO_RD_ADAPTER_CNT_EN to add the word_cnt handshake counter.
module fifo_rd_adapter
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rst_glb_n,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
`ifdef FIFO_RD_ADAPTER_CNT_EN
    output logic [CNT_WIDTH-1:0]  word_cnt,
`endif
    output logic [DATA_WIDTH-1:0] m_data
);

    logic                  r_inflight;
    logic                  w_pop;
    occ_t                  w_occ;
    logic [DATA_WIDTH-1:0] w_head_data;

    assign w_pop   = m_valid && m_ready;
    assign m_valid = (w_occ != '0);
    assign m_data  = w_head_data;

    // m_ready feeds fifo_rd_en directly so a pop frees credit in the same cycle
    assign fifo_rd_en = rst_glb_n && !fifo_empty && has_credit(w_occ, r_inflight, w_pop);

    // Data for a read issued last cycle is on fifo_rd_data this cycle
    always_ff @(posedge rd_clk or negedge rst_glb_n) begin
        if (!rst_glb_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
        end
    end

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (rd_clk),
        .rst_n     (rst_glb_n),
        .push      (r_inflight),
        .push_data (fifo_rd_data),
        .pop       (w_pop),
        .occ       (w_occ),
        .head_data (w_head_data)
    );

`ifdef FIFO_RD_ADAPTER_CNT_EN
    logic [CNT_WIDTH-1:0] r_word_cnt;

    always_ff @(posedge rd_clk or negedge rst_glb_n) begin
        if (!rst_glb_n) begin
            r_word_cnt <= '0;
        end else if (w_pop) begin
            r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
        end
    end

    assign word_cnt = r_word_cnt;
`else
    // CNT_WIDTH only sizes the counter, which is not built here
    if (CNT_WIDTH == 0) begin : g_no_cnt
    end
`endif

endmodule
